// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding and its reverse helper.
package snake_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  // Directions are laid out so that flipping bit 1 gives the 180-degree turn.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO holding queued turn directions.
// Reads are combinational from the head slot, so a push into a full FIFO
// is safe in the same cycle as a pop: the old head is read before the
// write lands on the same slot at the clock edge.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DIR_W-1:0] din,
  input  logic             pop,
  output logic [DIR_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [DIR_W-1:0] mem_q [DEPTH];
  logic [DIR_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/dir_cmd_queue.sv
// Turn command queue: arbitrates key-release pulses, rejects same/reverse
// turns, buffers legal turns and applies one per game tick to the heading.
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter dir_t RESET_DIR = RIGHT,
  localparam int  CW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             press_up,
  input  logic             press_right,
  input  logic             press_down,
  input  logic             press_left,
  input  logic             tick,
  output logic [DIR_W-1:0] heading,
  output logic             turned,
  output logic             dropped,
  output logic [CW-1:0]    count
);

  dir_t             heading_q, heading_d;
  dir_t             last_dir_q, last_dir_d;
  logic             turned_q, turned_d;
  logic             dropped_q, dropped_d;

  dir_t             cand;
  logic             has_cand;
  logic             legal;
  logic             push;
  logic             pop;
  logic [DIR_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // Pick one press per cycle (up > right > down > left), filter it against
  // the last accepted direction, and decide push/pop and the output pulses.
  always_comb begin
    has_cand = 1'b1;
    cand     = UP;
    if (press_up)         cand = UP;
    else if (press_right) cand = RIGHT;
    else if (press_down)  cand = DOWN;
    else if (press_left)  cand = LEFT;
    else                  has_cand = 1'b0;

    legal = (cand != last_dir_q) && (cand != opposite(last_dir_q));
    pop   = tick && !fifo_empty;
    push  = has_cand && legal && (!fifo_full || pop);

    last_dir_d = push ? cand : last_dir_q;
    heading_d  = pop ? dir_t'(fifo_dout) : heading_q;
    turned_d   = pop;
    dropped_d  = has_cand && !push;
  end

  // Heading, last accepted direction and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      heading_q  <= RESET_DIR;
      last_dir_q <= RESET_DIR;
      turned_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      heading_q  <= heading_d;
      last_dir_q <= last_dir_d;
      turned_q   <= turned_d;
      dropped_q  <= dropped_d;
    end
  end

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign heading = heading_q;
  assign turned  = turned_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Directed bench for dir_cmd_queue: a table of single-cycle vectors with
// hand-computed expectations, followed by a reset-in-flight sequence.
module tb_dir_cmd_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       press_up, press_right, press_down, press_left, tick;
  logic [1:0] heading;
  logic       turned, dropped;
  logic [2:0] count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic       u, r, d, l, t;
    logic [1:0] exp_heading;
    logic       exp_turned;
    logic       exp_dropped;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  dir_cmd_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .press_up    (press_up),
    .press_right (press_right),
    .press_down  (press_down),
    .press_left  (press_left),
    .tick        (tick),
    .heading     (heading),
    .turned      (turned),
    .dropped     (dropped),
    .count       (count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic u, r, d, l, t,
                              input logic [1:0] h, input logic tu,
                              input logic dr, input logic [2:0] c);
    vec_t v;
    v.u = u; v.r = r; v.d = d; v.l = l; v.t = t;
    v.exp_heading = h; v.exp_turned = tu; v.exp_dropped = dr; v.exp_count = c;
    return v;
  endfunction

  task automatic check_value(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [1:0] h, input logic tu,
                              input logic dr, input logic [2:0] c);
    check_value({tag, " heading"}, int'(heading), int'(h));
    check_value({tag, " turned"},  int'(turned),  int'(tu));
    check_value({tag, " dropped"}, int'(dropped), int'(dr));
    check_value({tag, " count"},   int'(count),   int'(c));
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic apply_stimulus(input logic u, r, d, l, t);
    press_up = u; press_right = r; press_down = d; press_left = l; tick = t;
    @(posedge clk);
    #1;
    press_up = 0; press_right = 0; press_down = 0; press_left = 0; tick = 0;
  endtask

  initial begin
    //           u r d l t   h  tu dr c
    vecs.push_back(mk(0,0,0,0,1, 1, 0, 0, 0)); // idle ticks, empty queue
    vecs.push_back(mk(0,0,0,0,1, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,1, 1, 0, 0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1, 0, 0, 1)); // up queued
    vecs.push_back(mk(0,0,0,0,0, 1, 0, 0, 1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0, 0, 1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0, 0, 1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0, 0, 1));
    vecs.push_back(mk(0,0,0,0,1, 0, 1, 0, 0)); // tick applies UP
    vecs.push_back(mk(0,0,0,0,0, 0, 0, 0, 0)); // turned is one cycle
    vecs.push_back(mk(0,1,0,0,0, 0, 0, 0, 1)); // back to RIGHT
    vecs.push_back(mk(0,0,0,0,1, 1, 1, 0, 0));
    vecs.push_back(mk(0,0,0,1,0, 1, 0, 1, 0)); // reverse rejected
    vecs.push_back(mk(0,1,0,0,0, 1, 0, 1, 0)); // same rejected
    vecs.push_back(mk(0,0,0,0,0, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,1, 1, 0, 0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1, 0, 0, 1)); // fill: up left down right
    vecs.push_back(mk(0,0,0,1,0, 1, 0, 0, 2));
    vecs.push_back(mk(0,0,1,0,0, 1, 0, 0, 3));
    vecs.push_back(mk(0,1,0,0,0, 1, 0, 0, 4));
    vecs.push_back(mk(1,0,0,0,0, 1, 0, 1, 4)); // legal but full
    vecs.push_back(mk(0,0,0,0,1, 0, 1, 0, 3)); // drain 0,3,2,1
    vecs.push_back(mk(0,0,0,0,1, 3, 1, 0, 2));
    vecs.push_back(mk(0,0,0,0,1, 2, 1, 0, 1));
    vecs.push_back(mk(0,0,0,0,1, 1, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,1, 1, 0, 0, 0)); // tick on empty
    vecs.push_back(mk(1,0,0,0,0, 1, 0, 0, 1)); // refill
    vecs.push_back(mk(0,0,0,1,0, 1, 0, 0, 2));
    vecs.push_back(mk(0,0,1,0,0, 1, 0, 0, 3));
    vecs.push_back(mk(0,1,0,0,0, 1, 0, 0, 4));
    vecs.push_back(mk(1,0,0,0,1, 0, 1, 0, 4)); // full push with pop accepted
    vecs.push_back(mk(0,0,0,0,1, 3, 1, 0, 3));
    vecs.push_back(mk(0,0,0,0,1, 2, 1, 0, 2));
    vecs.push_back(mk(0,0,0,0,1, 1, 1, 0, 1));
    vecs.push_back(mk(0,0,0,0,1, 0, 1, 0, 0)); // the UP pushed while full
    vecs.push_back(mk(0,1,0,0,1, 0, 0, 0, 1)); // no bypass on empty
    vecs.push_back(mk(0,0,0,0,1, 1, 1, 0, 0));
    vecs.push_back(mk(1,0,0,1,0, 1, 0, 0, 1)); // up wins over left, no drop
    vecs.push_back(mk(0,0,0,1,0, 1, 0, 0, 2)); // left legal after up

    press_up = 0; press_right = 0; press_down = 0; press_left = 0; tick = 0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset", 2'd1, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].u, vecs[i].r, vecs[i].d, vecs[i].l, vecs[i].t);
      check_output($sformatf("vec%0d", i), vecs[i].exp_heading,
                   vecs[i].exp_turned, vecs[i].exp_dropped, vecs[i].exp_count);
    end

    // Reset with two entries queued, while a tick and a would-be-dropped
    // press arrive in the same cycle: everything must be discarded.
    reset = 1'b1;
    apply_stimulus(0, 1, 0, 0, 1);
    check_output("midreset", 2'd1, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("post_reset_tick", 2'd1, 1'b0, 1'b0, 3'd0);
    // last_dir must be back to RIGHT: right is now a same-direction press.
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("post_reset_same", 2'd1, 1'b0, 1'b1, 3'd0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("post_reset_down", 2'd1, 1'b0, 1'b0, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dir_cmd_queue.md
Name: dir_cmd_queue

Overview:
- Consumer end of the press-pulse interface. It accepts the one-cycle "key released" pulses from the four per-button input conditioners (up/down/left/right).
- Filters out illegal turns, buffers legal turns in a small FIFO, and applies one turn per game step strobe from the tick generator.
- Drives the current snake heading to the movement/board-update logic.
- Lets the player queue fast multi-key turns between steps without losing presses or allowing a 180-degree reversal.

Parameters:
- DEPTH, 4, number of queued turns; power of two, at least 2.
- RESET_DIR, 2'd1 (RIGHT), heading after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- press_up  in  1  one-cycle release pulse, up key
- press_right  in  1  one-cycle release pulse, right key
- press_down  in  1  one-cycle release pulse, down key
- press_left  in  1  one-cycle release pulse, left key
- tick  in  1  one-cycle game step strobe
- heading  out  2  current direction: UP=0, RIGHT=1, DOWN=2, LEFT=3
- turned  out  1  one-cycle pulse: heading changed this cycle
- dropped  out  1  one-cycle pulse: a press was rejected (illegal or full)
- count  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset values: heading=RESET_DIR, turned=0, dropped=0, count=0, FIFO pointers=0, last_dir=RESET_DIR.
- Press arbitration, same cycle:
  - Priority is up > right > down > left; exactly one candidate per cycle.
  - Lower-priority simultaneous presses are discarded silently; dropped is not asserted for them.
- Legality filter compares the candidate against last_dir, the direction of the most recently accepted entry (equal to heading whenever the queue is empty):
  - same as last_dir: reject, dropped=1 next cycle.
  - reverse (candidate == last_dir XOR 2): reject, dropped=1 next cycle.
  - otherwise legal.
- Push:
  - A legal candidate with count<DEPTH is written at the tail; last_dir takes the candidate.
  - A legal candidate with count==DEPTH and no pop this cycle is rejected with dropped=1 and last_dir unchanged.
  - A legal candidate with count==DEPTH and a pop in the same cycle is accepted.
- Pop:
  - On tick with count>0 (count before this cycle's push), the head entry is loaded into heading at the next clock edge; turned=1 for that one cycle.
  - tick with count==0: heading unchanged, turned=0.
  - No bypass: a press in the same cycle as tick on an empty queue is queued and applied at the next tick.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- count arithmetic: count_next = count + push − pop, never outside 0..DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Latency:
  - press to enqueue: 1 cycle.
  - tick to heading update and turned pulse: 1 cycle.
  - Best case press to heading change: press registered, then the next tick.
- Outputs turned and dropped are registered pulses, never more than one cycle wide per event.
- A reset asserted mid-operation discards all queued turns, returns heading to RESET_DIR, and suppresses any pending turned/dropped pulse in the cycle following reset.
- Inputs are already synchronous one-cycle pulses from the input conditioners; this block does no edge detection or debouncing.

Decomposition:
- Shared package snake_pkg holds:
  - dir_t enum {UP=0, RIGHT=1, DOWN=2, LEFT=3}.
  - Function opposite(dir_t), implemented as XOR 2.
  - Constant DIR_W=2.
- One natural sub-module: dir_fifo, a parameterised synchronous FIFO (DEPTH x DIR_W) with push/pop/full/empty/count.
- dir_cmd_queue keeps arbitration, the legality filter, last_dir, and the heading register.

Test Plan:
- Reset, no presses, 3 ticks -> heading=1 throughout; turned never asserted; count=0.
- press_up, then tick 5 cycles later -> count=1 one cycle after the press; heading=0 and turned=1 one cycle after the tick; count=0.
- From heading RIGHT, press_left (reverse), then press_right (same) -> dropped pulses twice; count stays 0; a following tick leaves heading=1.
- Presses up, left, down, right, up with no tick (DEPTH=4) -> first four accepted (count=4); fifth dropped; then 4 ticks give headings 0, 3, 2, 1 with turned on each.
- Queue full (count=4); press legal vs last_dir in the same cycle as tick -> accepted; count stays 4; heading takes the old head.
- press_up and press_left in the same cycle from RIGHT -> only UP queued; dropped=0. Assert reset with 2 entries queued -> count=0, heading=1, no turned on the next tick.
